// File: rtl/pwm_timebase.sv
// PWM time-base: prescaled up/down/up-down counter with a shadowed period,
// one-shot runs and top/bottom event pulses for the compare stages.
//
//   state (dir) | meaning
//   ------------+------------------------------------------------------
//   1           | counting up (up mode, or rising half of up-down)
//   0           | counting down (down mode, or falling half of up-down)
module pwm_timebase #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      PS_WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_PERIOD = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                count_reset,
  input  logic [1:0]          mode,
  input  logic                one_shot,
  input  logic                start,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                period_load,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]    count_val,
  output logic                dir,
  output logic                ovf,
  output logic                unf,
  output logic                running,
  output logic [WIDTH-1:0]    active_period
);

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UPDN = 2'b10;

  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic                dir_q, dir_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                armed_q, armed_d;
  logic                pending_q, pending_d;

  logic                running_w;
  logic                tick;
  logic                upd_evt;
  logic                mode_dir;
  logic [WIDTH-1:0]    period_upd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      period_q  <= RESET_PERIOD;
      shadow_q  <= RESET_PERIOD;
      ps_q      <= '0;
      dir_q     <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      ps_q      <= ps_d;
      dir_q     <= dir_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  // Period that an update event would install; a coincident load wins
  always_comb begin
    running_w  = en & (~one_shot | armed_q);
    tick       = running_w && (ps_q >= prescale);
    mode_dir   = (mode != MODE_DOWN);
    if (period_load)
      period_upd = period_in;
    else if (pending_q)
      period_upd = shadow_q;
    else
      period_upd = period_q;
  end

  // Next-state logic
  always_comb begin
    count_d   = count_q;
    dir_d     = dir_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ps_d      = ps_q;
    armed_d   = armed_q;
    period_d  = period_q;
    shadow_d  = period_load ? period_in : shadow_q;
    pending_d = pending_q | period_load;
    upd_evt   = 1'b0;

    if (running_w)
      ps_d = tick ? '0 : ps_q + 1'b1;

    if (tick) begin
      case (mode)
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (count_q == '0) begin
            count_d = period_upd;
            unf_d   = 1'b1;
            upd_evt = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        MODE_UPDN: begin
          // Zero period degenerates into both events every tick
          if (period_q == '0) begin
            count_d = '0;
            dir_d   = 1'b1;
            ovf_d   = 1'b1;
            unf_d   = 1'b1;
            upd_evt = 1'b1;
          end else if (dir_q && (count_q >= period_q)) begin
            count_d = period_q - 1'b1;
            dir_d   = 1'b0;
            ovf_d   = 1'b1;
          end else if (!dir_q && (count_q == '0)) begin
            count_d = WIDTH'(1);
            dir_d   = 1'b1;
            unf_d   = 1'b1;
            upd_evt = 1'b1;
          end else begin
            count_d = dir_q ? count_q + 1'b1 : count_q - 1'b1;
          end
        end
        default: begin
          dir_d = 1'b1;
          if (count_q >= period_q) begin
            count_d = '0;
            ovf_d   = 1'b1;
            upd_evt = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      endcase
    end

    if (upd_evt) begin
      period_d  = period_upd;
      pending_d = 1'b0;
      if (one_shot)
        armed_d = 1'b0;
    end

    // A start landing on the final update event re-arms the next run
    if (start)
      armed_d = 1'b1;

    if (count_reset) begin
      count_d   = '0;
      ps_d      = '0;
      dir_d     = mode_dir;
      armed_d   = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      period_d  = period_upd;
      pending_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    count_val     = count_q;
    dir           = dir_q;
    ovf           = ovf_q;
    unf           = unf_q;
    active_period = period_q;
    running       = running_w;
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: expected per-cycle outputs are queued as
// stimulus is applied and checked one entry per clock after the active edge.
module tb_pwm_timebase;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        count_reset;
  logic [1:0]  mode;
  logic        one_shot;
  logic        start;
  logic [15:0] period_in;
  logic        period_load;
  logic [7:0]  prescale;
  logic [15:0] count_val;
  logic        dir;
  logic        ovf;
  logic        unf;
  logic        running;
  logic [15:0] active_period;

  pwm_timebase dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .count_reset   (count_reset),
    .mode          (mode),
    .one_shot      (one_shot),
    .start         (start),
    .period_in     (period_in),
    .period_load   (period_load),
    .prescale      (prescale),
    .count_val     (count_val),
    .dir           (dir),
    .ovf           (ovf),
    .unf           (unf),
    .running       (running),
    .active_period (active_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] count;
    logic        dir;
    logic        ovf;
    logic        unf;
    logic [15:0] per;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [15:0] c, input logic d, input logic o,
                               input logic u, input logic [15:0] p);
    exp_t e;
    e.count = c;
    e.dir   = d;
    e.ovf   = o;
    e.unf   = u;
    e.per   = p;
    sb.push_back(e);
  endfunction

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb_empty: observed no expectation queued at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        chk("count", 32'(count_val), 32'(e.count));
        chk("dir", 32'(dir), 32'(e.dir));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("unf", 32'(unf), 32'(e.unf));
        chk("active_period", 32'(active_period), 32'(e.per));
      end
    end
    chk("sb_drain", 32'(sb.size()), 32'(0));
  endtask

  // Load a period and clear the counter in one cycle, counter stopped
  task automatic setup(input logic [1:0] m, input logic [15:0] p, input logic os);
    en          = 1'b0;
    mode        = m;
    one_shot    = os;
    period_in   = p;
    period_load = 1'b1;
    count_reset = 1'b1;
    @(posedge clk);
    #1;
    period_load = 1'b0;
    count_reset = 1'b0;
    chk("setup_period", 32'(active_period), 32'(p));
    chk("setup_count", 32'(count_val), 32'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    count_reset = 1'b0;
    mode        = 2'b00;
    one_shot    = 1'b0;
    start       = 1'b0;
    period_in   = 16'h0;
    period_load = 1'b0;
    prescale    = 8'd0;
    #12;
    chk("rst_count", 32'(count_val), 32'(0));
    chk("rst_dir", 32'(dir), 32'(1));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_unf", 32'(unf), 32'(0));
    chk("rst_period", 32'(active_period), 32'hFFFF);
    chk("rst_running", 32'(running), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Up, P=3
    setup(2'b00, 16'd3, 1'b0);
    en = 1'b1;
    push(1, 1, 0, 0, 3); push(2, 1, 0, 0, 3); push(3, 1, 0, 0, 3); push(0, 1, 1, 0, 3);
    push(1, 1, 0, 0, 3); push(2, 1, 0, 0, 3); push(3, 1, 0, 0, 3); push(0, 1, 1, 0, 3);
    run(8);

    // Down, P=2, prescale 1
    setup(2'b01, 16'd2, 1'b0);
    chk("down_dir", 32'(dir), 32'(0));
    prescale = 8'd1;
    en = 1'b1;
    push(0, 0, 0, 0, 2); push(2, 0, 0, 1, 2); push(2, 0, 0, 0, 2); push(1, 0, 0, 0, 2);
    push(1, 0, 0, 0, 2); push(0, 0, 0, 0, 2); push(0, 0, 0, 0, 2); push(2, 0, 0, 1, 2);
    run(8);
    prescale = 8'd0;

    // Up-down, P=3, then leave to up mode while falling
    setup(2'b10, 16'd3, 1'b0);
    en = 1'b1;
    push(1, 1, 0, 0, 3); push(2, 1, 0, 0, 3); push(3, 1, 0, 0, 3); push(2, 0, 1, 0, 3);
    push(1, 0, 0, 0, 3); push(0, 0, 0, 0, 3); push(1, 1, 0, 1, 3); push(2, 1, 0, 0, 3);
    push(3, 1, 0, 0, 3); push(2, 0, 1, 0, 3);
    run(10);
    mode = 2'b00;
    push(3, 1, 0, 0, 3); push(0, 1, 1, 0, 3);
    run(2);

    // Zero period in every mode
    setup(2'b10, 16'd0, 1'b0);
    en = 1'b1;
    push(0, 1, 1, 1, 0); push(0, 1, 1, 1, 0); push(0, 1, 1, 1, 0);
    run(3);
    mode = 2'b01;
    push(0, 0, 0, 1, 0); push(0, 0, 0, 1, 0);
    run(2);
    mode = 2'b00;
    push(0, 1, 1, 0, 0); push(0, 1, 1, 0, 0);
    run(2);

    // Shadowed period load mid-period
    setup(2'b00, 16'd5, 1'b0);
    en = 1'b1;
    push(1, 1, 0, 0, 5);
    run(1);
    period_in   = 16'd2;
    period_load = 1'b1;
    push(2, 1, 0, 0, 5);
    run(1);
    period_load = 1'b0;
    push(3, 1, 0, 0, 5); push(4, 1, 0, 0, 5); push(5, 1, 0, 0, 5); push(0, 1, 1, 0, 2);
    push(1, 1, 0, 0, 2); push(2, 1, 0, 0, 2); push(0, 1, 1, 0, 2);
    run(7);

    // Prescale reduced below ps_cnt, then enable freeze
    setup(2'b00, 16'd100, 1'b0);
    prescale = 8'd5;
    en = 1'b1;
    push(0, 1, 0, 0, 100); push(0, 1, 0, 0, 100); push(0, 1, 0, 0, 100);
    run(3);
    prescale = 8'd1;
    push(1, 1, 0, 0, 100); push(1, 1, 0, 0, 100); push(2, 1, 0, 0, 100);
    run(3);
    en = 1'b0;
    push(2, 1, 0, 0, 100); push(2, 1, 0, 0, 100);
    run(2);
    prescale = 8'd0;

    // One-shot up, P=2
    setup(2'b00, 16'd2, 1'b1);
    en = 1'b1;
    push(0, 1, 0, 0, 2); push(0, 1, 0, 0, 2); push(0, 1, 0, 0, 2);
    run(3);
    chk("os_idle_running", 32'(running), 32'(0));
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      push(0, 1, 0, 0, 2);
      run(1);
      start = 1'b0;
      chk("os_armed_running", 32'(running), 32'(1));
      push(1, 1, 0, 0, 2); push(2, 1, 0, 0, 2); push(0, 1, 1, 0, 2);
      push(0, 1, 0, 0, 2); push(0, 1, 0, 0, 2);
      run(5);
      chk("os_done_running", 32'(running), 32'(0));
    end
    one_shot = 1'b0;

    // Async reset at count 7 in up-down with a pending load
    setup(2'b10, 16'd10, 1'b0);
    en = 1'b1;
    push(1, 1, 0, 0, 10); push(2, 1, 0, 0, 10); push(3, 1, 0, 0, 10); push(4, 1, 0, 0, 10);
    push(5, 1, 0, 0, 10); push(6, 1, 0, 0, 10); push(7, 1, 0, 0, 10);
    run(7);
    period_in   = 16'd4;
    period_load = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    period_load = 1'b0;
    chk("arst_count", 32'(count_val), 32'(0));
    chk("arst_dir", 32'(dir), 32'(1));
    chk("arst_ovf", 32'(ovf), 32'(0));
    chk("arst_unf", 32'(unf), 32'(0));
    chk("arst_period", 32'(active_period), 32'hFFFF);
    @(negedge clk);
    rst_n       = 1'b1;
    en          = 1'b0;
    count_reset = 1'b1;
    @(posedge clk);
    #1;
    count_reset = 1'b0;
    chk("arst_pending_dropped", 32'(active_period), 32'hFFFF);
    chk("arst_count_after", 32'(count_val), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Parametrised PWM time-base counter with prescaler, up / down / up-down (centre-aligned) modes, shadowed period register, one-shot operation and overflow/underflow event pulses. It drives the compare stages of the PWM generator. Period updates take effect only at a period boundary, so no glitched cycle is ever produced.

## Interface
- WIDTH, 16, width of counter and period
- PS_WIDTH, 8, width of prescale input
- RESET_PERIOD, 16'hFFFF, active period after reset
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable; 0 freezes count and prescaler
- count_reset  in  1  synchronous clear, priority over everything except rst_n
- mode  in  2  00 up, 01 down, 10 up-down, 11 treated as up
- one_shot  in  1  1 = stop after one period
- start  in  1  arms one-shot run (single-cycle pulse)
- period_in  in  WIDTH  new period value
- period_load  in  1  writes period_in to shadow, sets pending
- prescale  in  PS_WIDTH  tick every prescale+1 enabled cycles
- count_val  out  WIDTH  counter value
- dir  out  1  1 = counting up
- ovf  out  1  one-cycle pulse on top event
- unf  out  1  one-cycle pulse on bottom event
- running  out  1  combinational: en & (!one_shot | armed)
- active_period  out  WIDTH  period in use (P)

## Operation
- Reset: count_val 0, ps_cnt 0, dir 1, ovf/unf 0, armed 0, pending 0, shadow and active_period = RESET_PERIOD.
- Prescaler: while running, ps_cnt increments; tick when ps_cnt >= prescale, then ps_cnt <= 0. prescale 0 → tick every cycle. Not running → ps_cnt and count_val hold.
- Up: on tick, count==P or count>P → count 0, ovf=1, update event; else count+1. dir=1.
- Down: on tick, count==0 → count = P (P after update applied), unf=1, update event; else count-1. dir=0.
- Up-down: dir=1 and count>=P → dir 0, count P-1, ovf=1. dir=0 and count==0 → dir 1, count 1, unf=1, update event. Otherwise ±1 by dir. Full cycle = 2P ticks.
- P=0: up → ovf every tick; down → unf every tick; up-down → ovf and unf every tick, dir stays 1. count stays 0.
- Mode change takes effect on next tick; on leaving up-down, dir forced to mode default (up 1, down 0).
- Update event: if pending, active_period <= shadow, pending cleared. period_load coincident with update event → period_in applied directly, pending stays 0.
- count_reset: count 0, ps_cnt 0, dir = mode default (up-down: 1), armed 0, ovf/unf 0; pending shadow (or coincident period_in) applied immediately.
- One-shot: start sets armed. With one_shot=1, update event clears armed; counter holds post-wrap value (up 0, down P, up-down 1). start coincident with that update event keeps armed=1. one_shot=0 ignores armed.

## Timing
- All outputs registered except running.
- ovf/unf assert in the same cycle count_val shows the wrapped/turned value, for exactly one clk cycle.
- Tick-to-count latency 1 clk; first tick after enable from ps_cnt=0 occurs after prescale+1 enabled cycles.
- rst_n assertion mid-operation clears all state immediately (async); deassertion sampled by clk.
- prescale may change anytime; reduction below ps_cnt yields tick on next enabled cycle.

## Test plan
- Up, P=3, prescale=0, en=1: count 0,1,2,3,0…; ovf high only in cycles showing 0 after 3.
- Down, P=2, prescale=1: count changes every 2 cycles 0→2→1→0→2; unf on each 0→2 transition.
- Up-down, P=3: 0,1,2,3,2,1,0,1…; ovf with 2 after 3, unf with 1 after 0; dir tracks.
- Up, P=5, period_load 2 at count=1: continues to 5, wraps, then 0,1,2,0; active_period changes to 2 on wrap cycle.
- One-shot up, P=2: without start count holds 0; start → 0,1,2,0 then holds, running drops; second start repeats.
- rst_n low at count=7 in up-down with pending load: all outputs reset values, active_period = RESET_PERIOD, pending discarded.
